// File: rtl/pc.sv
// Program counter: a single Psize-bit register that advances by one
// when the controller requests it and the stall flag permits.
module pc #(
  parameter int Psize = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCincr,
  input  logic             flag,
  output logic [Psize-1:0] PCout
);

  logic [Psize-1:0] r_pc;

  // Reset wins over increment; the carry-out is dropped, so the top value wraps to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (PCincr && flag) begin
      r_pc <= r_pc + Psize'(1);
    end
  end

  assign PCout = r_pc;

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: stimulus pushes hand-computed expectations,
// a monitor pops and compares after each edge or on a mid-cycle probe.
module tb_pc;

  localparam int PW = 6;

  logic          clk;
  logic          reset;
  logic          PCincr;
  logic          flag;
  logic [PW-1:0] PCout;

  typedef struct {
    string         name;
    logic [PW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  event mid_ev;

  pc #(.Psize(PW)) dut (
    .clk    (clk),
    .reset  (reset),
    .PCincr (PCincr),
    .flag   (flag),
    .PCout  (PCout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one comparison per pending expectation, 1 time unit after the trigger.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or mid_ev);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (PCout !== e.val) begin
          errors++;
          $display("FAIL %s: PCout=%0d expected=%0d", e.name, PCout, e.val);
        end else begin
          $display("ok   %s: PCout=%0d", e.name, PCout);
        end
      end
    end
  end

  task automatic push(input string name, input logic [PW-1:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    q.push_back(e);
  endtask

  // One edge: drive at the falling edge, expect `v` after the following rising edge.
  task automatic step(input logic r, input logic inc, input logic f,
                      input string name, input logic [PW-1:0] v);
    @(negedge clk);
    reset  = r;
    PCincr = inc;
    flag   = f;
    push(name, v);
    @(posedge clk);
  endtask

  // Drive inputs mid-cycle, probe that PCout has not moved, then finish the cycle.
  task automatic glitch_step(input logic r, input logic inc, input logic f,
                             input logic [PW-1:0] now_v,
                             input logic r2, input logic inc2, input logic f2,
                             input string name, input logic [PW-1:0] v);
    @(negedge clk);
    reset  = r;
    PCincr = inc;
    flag   = f;
    push({name, "_mid"}, now_v);
    -> mid_ev;
    #2;
    reset  = r2;
    PCincr = inc2;
    flag   = f2;
    push(name, v);
    @(posedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    PCincr = 1'b1;
    flag   = 1'b1;

    // Reset with increment asserted
    step(1, 1, 1, "reset", 0);

    // Hold: PCincr=0, flag toggling every 2 cycles
    step(0, 0, 1, "hold0", 0);
    step(0, 0, 1, "hold1", 0);
    step(0, 0, 0, "hold2", 0);
    step(0, 0, 0, "hold3", 0);
    step(0, 0, 1, "hold4", 0);

    // Count 1..5
    step(0, 1, 1, "count1", 1);
    step(0, 1, 1, "count2", 2);
    step(0, 1, 1, "count3", 3);
    step(0, 1, 1, "count4", 4);
    step(0, 1, 1, "count5", 5);

    // Stall at 5, then release
    step(0, 1, 0, "stall0", 5);
    step(0, 1, 0, "stall1", 5);
    step(0, 1, 1, "stall_rel", 6);

    // Flag pulses high between edges but is low at the edge: hold
    glitch_step(0, 1, 1, 6, 0, 1, 0, "flag_glitch", 6);

    // Advance to 10
    step(0, 1, 1, "adv7", 7);
    step(0, 1, 1, "adv8", 8);
    step(0, 1, 1, "adv9", 9);
    step(0, 1, 1, "adv10", 10);

    // Mid-count reset raised between edges: PCout still 10 until the edge
    glitch_step(1, 1, 1, 10, 1, 1, 1, "midrst", 0);
    step(0, 1, 1, "resume", 1);

    // Wrap: from 0, 64 increments return to 0
    step(1, 0, 0, "wrap_rst", 0);
    for (int k = 1; k <= 64; k++) begin
      step(0, 1, 1, $sformatf("wrap%0d", k), PW'(k % 64));
    end
    step(0, 1, 1, "post_wrap", 1);

    // Drain: every expectation must have been consumed
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 Parameter: Psize, default 6, width in bits of the program counter and of PCout.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk only.
REQ-004 Port: PCincr  input  1  increment request from the controller.
REQ-005 Port: flag  input  1  advance enable; 1 = advance permitted, 0 = hold (stall, e.g. waiting on a switch).
REQ-006 Port: PCout  output  Psize  current program counter value, driven directly from the PC register.

Function
REQ-007 The block SHALL hold one Psize-bit register, PC, and PCout SHALL equal PC at all times, with no combinational path from any input to PCout.
REQ-008 At each rising clk edge with reset=0, PCincr=1 and flag=1, PC SHALL become (PC + 1) mod 2^Psize.
REQ-009 At each rising clk edge with reset=0 and either PCincr=0 or flag=0, PC SHALL hold its value.
REQ-010 Increment latency SHALL be one clock: PCout changes on the same edge that samples PCincr=1 and flag=1.
REQ-011 Wrap-around: PC = 2^Psize-1 with an increment SHALL yield 0, with no error indication.
REQ-012 Inputs SHALL be level-sampled each edge, with no edge detection. A sustained PCincr=1 and flag=1 SHALL advance PC once per cycle.
REQ-013 A change on flag or PCincr between edges SHALL have no effect on PCout until the next rising edge.
REQ-014 Arithmetic SHALL be unsigned Psize-bit, with the carry-out discarded.

Reset
REQ-015 reset=1 at a rising edge SHALL force PC to 0, regardless of PCincr and flag.
REQ-016 Reset SHALL take priority over increment when both are asserted on the same edge.
REQ-017 Reset asserted mid-count SHALL clear PC on the next edge.
REQ-018 Counting SHALL resume from 0 on the first edge after reset deasserts.
REQ-019 Reset asserted between clock edges SHALL NOT affect PCout before the next rising edge.
REQ-020 PCout SHALL be 0 after the first edge with reset=1. PC is undefined before that edge, and the bench SHALL apply reset before checking.

Structure
REQ-021 No shared package is required. Psize is the only constant and SHALL remain a module parameter, overridable at instantiation.
REQ-022 The block SHALL be a single module with one clocked process and no sub-modules.
REQ-023 The design SHALL be synthesizable for any Psize from 1 to 32.

Verification
REQ-024 Reset: reset=1 for 1 cycle with PCincr=1 and flag=1 -> PCout=0 after the edge.
REQ-025 Hold: reset=0, PCincr=0, flag toggled 1/0 every 2 cycles over 5 cycles -> PCout stays 0.
REQ-026 Count: PCincr=1, flag=1 for 5 cycles starting at PC=0 -> PCout reads 1, 2, 3, 4, 5 on successive edges.
REQ-027 Stall: PCincr=1, flag=0 for 2 cycles at PC=5, then flag=1 -> PCout reads 5, 5, 6.
REQ-028 Wrap (Psize=6): 64 consecutive increments from 0 -> PCout returns to 0; the edge from 63 yields 0.
REQ-029 Mid-count reset: PC=10, then reset=1 for one edge with PCincr=1 -> PCout=0; with reset=0 on the next edge -> PCout=1.
